bist_march_controller: RTL

Parametrised March C- BIST controller for the single-port synchronous SRAM under test. It replaces the start/cout/ld/NbarT controller, which relied on an external address counter. This block owns address generation, read/write sequencing, data backgrounds and read-data comparison, and reports done/fail. It sits between the SRAM wrapper's normal-mode mux (steered by `NbarT`) and the SRAM macro.

---
 rtl/bist_pkg.sv | 13 +
 rtl/bist_march_controller_if.sv | 13 +
 rtl/bist_addr_gen.sv | 20 ++
 rtl/bist_march_controller.sv | 127 ++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// bist_pkg: FSM states and March C- element tables shared by the BIST controller
package bist_pkg;
  typedef enum logic [2:0] {IDLE, LD, RUN, DRAIN, DONE} state_t;
  localparam int NUM_ELEMS = 6;
  // bit e of each table describes element e: E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 dn(r0,w1) E4 dn(r1,w0) E5 up(r0)
  localparam logic [NUM_ELEMS-1:0] ELEM_UP      = 6'b100111;
  localparam logic [NUM_ELEMS-1:0] ELEM_TWO_OPS = 6'b011110;
  localparam logic [NUM_ELEMS-1:0] ELEM_RVAL    = 6'b010100;
  localparam logic [NUM_ELEMS-1:0] ELEM_WVAL    = 6'b001010;
  function automatic logic op_is_write(input logic [2:0] elem, input logic op);
    return ELEM_TWO_OPS[elem] ? op : (elem == 3'd0);
  endfunction
endpackage

// File: rtl/bist_march_controller_if.sv
// bist_march_controller_if: single-port SRAM access bus between BIST controller and SRAM
interface bist_march_controller_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport master (output mem_en, mem_we, mem_addr, mem_wdata, input mem_rdata);
  modport slave  (input mem_en, mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/bist_addr_gen.sv
// bist_addr_gen: loadable up/down address counter with direction-aware terminal count
module bist_addr_gen #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              en,
  input  logic              up,
  output logic [ADDR_W-1:0] addr,
  output logic              cout
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) addr <= '0;
    else if (ld) addr <= up ? '0 : LAST;
    else if (en) addr <= up ? addr + 1'b1 : addr - 1'b1;
  assign cout = up ? (addr == LAST) : (addr == '0);
endmodule

// File: rtl/bist_march_controller.sv
// bist_march_controller: March C- BIST sequencer/comparator; define BIST_FAIL_LOG_EN to log first failing address/element
module bist_march_controller
  import bist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2**ADDR_W,
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    NbarT,
  output logic                    ld,
  output logic                    done,
  output logic                    fail,
  output logic [ADDR_W-1:0]       fail_addr,
  output logic [2:0]              fail_elem,
  bist_march_controller_if.master mem
);
  state_t            state, state_n;
  logic [2:0]        elem, elem_n;
  logic              op, op_n, clr, last_op, cout, we_n;
  logic              en_r, we_r, rd_v, rd_exp, mismatch;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata_r;
  assign last_op = (op == ELEM_TWO_OPS[elem]);
  bist_addr_gen #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .ld   (state == LD),
    .en   (state == RUN && last_op && !cout),
    .up   (ELEM_UP[elem]),
    .addr (addr),
    .cout (cout)
  );
  always_comb begin
    state_n = state;
    elem_n  = elem;
    op_n    = op;
    clr     = 1'b0;
    case (state)
      IDLE, DONE: if (start) begin
        state_n = LD;
        elem_n  = '0;
        op_n    = 1'b0;
        clr     = 1'b1;
      end
      LD: begin
        state_n = RUN;
        op_n    = 1'b0;
      end
      RUN: begin
        op_n = !last_op;
        if (last_op && cout) begin
          state_n = (elem == 3'(NUM_ELEMS - 1)) ? DRAIN : LD;
          elem_n  = (elem == 3'(NUM_ELEMS - 1)) ? elem : elem + 3'd1;
        end
      end
      DRAIN: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // outputs are decoded from the next state so every port comes straight from a flop
  assign we_n = (state_n == RUN) && op_is_write(elem_n, op_n);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      elem    <= '0;
      op      <= 1'b0;
      NbarT   <= 1'b0;
      ld      <= 1'b0;
      en_r    <= 1'b0;
      we_r    <= 1'b0;
      wdata_r <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      elem    <= elem_n;
      op      <= op_n;
      NbarT   <= state_n inside {LD, RUN, DRAIN};
      ld      <= (state_n == LD);
      en_r    <= (state_n == RUN);
      we_r    <= we_n;
      wdata_r <= we_n ? {DATA_W{ELEM_WVAL[elem_n]}} : '0;
      done    <= (state_n == DONE);
    end
  assign mem.mem_en    = en_r;
  assign mem.mem_we    = we_r;
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = wdata_r;
  // read data returns one cycle after issue, so expected background is delayed to meet it
  assign mismatch = rd_v && (mem.mem_rdata != {DATA_W{rd_exp}});
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_v   <= 1'b0;
      rd_exp <= 1'b0;
      fail   <= 1'b0;
    end else begin
      rd_v   <= en_r && !we_r;
      rd_exp <= ELEM_RVAL[elem];
      fail   <= clr ? 1'b0 : (fail || mismatch);
    end
`ifdef BIST_FAIL_LOG_EN
  logic [ADDR_W-1:0] rd_addr;
  logic [2:0]        rd_elem;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_addr   <= '0;
      rd_elem   <= '0;
      fail_addr <= '0;
      fail_elem <= '0;
    end else begin
      rd_addr <= addr;
      rd_elem <= elem;
      if (clr) begin
        fail_addr <= '0;
        fail_elem <= '0;
      end else if (mismatch && !fail) begin
        fail_addr <= rd_addr;
        fail_elem <= rd_elem;
      end
    end
`else
  assign fail_addr = '0;
  assign fail_elem = '0;
`endif
endmodule
